hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Parametrised hazard/forwarding controller for the in-order integer+FP pipeline.
//   Tracks in-flight register writes in a DEPTH-entry shift queue, one entry per post-decode stage.
//   For the two decode sources it picks the youngest forwardable producer or raises stall.
//   Variable per-op result latency (ALU, load, multiply) replaces fixed single-cycle reg_lock logic.
// PARAMETERS
//   DEPTH      3   post-decode stages tracked (1=EX, 2=MEM, 3=WB); range 2..8
//   IDX_W      5   register index width
//   NUM_RF     2   register files (0=GPR, 1=FPR); GPR r0 hardwired zero
//   RF_W       1   register-file select width, >= clog2(NUM_RF)
//   SEL_W      2   forward-select width, = clog2(DEPTH+1)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   issue_valid  in   1      decode presents an instruction this cycle
//   issue_we     in   1      instruction writes a register
//   issue_rf     in   RF_W   destination register file
//   issue_dst    in   IDX_W  destination index
//   issue_lat    in   SEL_W  first stage (1..DEPTH) where result exists; 0 is treated as 1
//   flush        in   1      squash the decode instruction (taken branch/jump)
//   src_a_en     in   1      source A used;   src_a_rf in RF_W;  src_a_idx in IDX_W
//   src_b_en     in   1      source B used;   src_b_rf in RF_W;  src_b_idx in IDX_W
//   stall        out  1      hold IF/ID; bubble enters EX
//   fwd_a_sel    out  SEL_W  0 = register file, k = bypass from stage k output
//   fwd_b_sel    out  SEL_W  as fwd_a_sel for source B
//   stall_count  out  32     saturating count of stall cycles
// BEHAVIOUR
//   Queue: entries q[1..DEPTH] {valid, rf, idx, lat}; q[k] is the producer now in stage k.
//   Every cycle q shifts: q[k+1] <= q[k]; q[DEPTH] drops out after its WB cycle.
//   q[1] <= issue fields when issue_valid & issue_we & ~stall & ~flush, else bubble (valid=0).
//   Match(src,k): src_en & q[k].valid & q[k].rf==src_rf & q[k].idx==src_idx
//     & ~(src_rf==0 & src_idx==0).
//   Youngest match wins: smallest k.
//     k >= q[k].lat  -> fwd_sel = k, no stall from this source.
//     k <  q[k].lat  -> stall from this source; fwd_sel = 0.
//   No match -> fwd_sel = 0.
//   Older matches behind a younger one are ignored, even when the younger one is not ready.
//   stall = hazard_a | hazard_b, gated by issue_valid & ~flush. Combinational; same-cycle outputs.
//   fwd_*_sel are combinational and valid only when stall=0.
//   Writer at q[DEPTH] writes the RF this cycle; a match there forwards as sel=DEPTH (WB bypass).
//   Same-cycle flush & stall: flush wins; stall=0, no entry inserted.
//   stall_count: +1 each cycle stall=1; holds at 32'hFFFF_FFFF.
//   Reset (synchronous): all q[k].valid=0, stall_count=0; hence stall=0 and fwd_*_sel=0 next cycle.
//   Reset mid-operation drops all in-flight entries; no stall may persist after reset.
//   Load-use with lat=2 and DEPTH=3: exactly one stall cycle, then sel=2 (MEM bypass).
//   Back-to-back writers to one register: sel always points at the youngest.
//   FPR index 0 is a normal register; only GPR r0 is exempt.
// STRUCTURE
//   Shared package pipeline_pkg:
//     RF_GPR/RF_FPR constants; FWD_REGFILE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3 select encodings;
//     sb_entry_t struct {valid, rf, idx, lat}.
//   One sub-module, hazard_src_match: per-source priority match over q.
//     Instantiated twice; outputs {hazard, fwd_sel}.
//   Top holds the shift queue, stall gating and counter.
// TESTING
//   1  Defaults: ADD r3 (lat=1), next cycle ADD reads r3
//        -> stall=0, fwd_a_sel=1.
//   2  LW r5 (lat=2), next cycle ADD reads r5 as B
//        -> stall=1 one cycle, then fwd_b_sel=2; stall_count=1.
//   3  Writes to r0: ADD r0 then read r0
//        -> stall=0, sel=0.
//      FPR f0 writer (lat=1) then read f0
//        -> fwd_a_sel=1.
//   4  ADD r7 (lat=1) then LW r7 (lat=2), then read r7
//        -> stall=1 (youngest LW not ready); older ADD in stage 2 ignored.
//   5  LW r4 then consumer of r4 with flush=1 same cycle
//        -> stall=0; queue inserts a bubble.
//   6  Reset asserted while q holds three writers to r9, then read r9
//        -> stall=0, fwd_a_sel=0, stall_count=0.
//      Also force stall_count to 32'hFFFF_FFFE, stall 3 cycles
//        -> count saturates at FFFF_FFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file ids, forward-select encodings and
// the scoreboard entry layout used by the hazard/forwarding controller.
package pipeline_pkg;

    localparam int RF_GPR = 0;
    localparam int RF_FPR = 1;

    localparam int FWD_REGFILE = 0;
    localparam int FWD_EX      = 1;
    localparam int FWD_MEM     = 2;
    localparam int FWD_WB      = 3;

    // Entry fields are sized for the widest legal configuration; modules zero-extend into them.
    localparam int SB_RF_MAX  = 3;
    localparam int SB_IDX_MAX = 8;
    localparam int SB_LAT_MAX = 4;

    typedef struct packed {
        logic                  valid;
        logic [SB_RF_MAX-1:0]  rf;
        logic [SB_IDX_MAX-1:0] idx;
        logic [SB_LAT_MAX-1:0] lat;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source priority match over the in-flight queue: youngest producer of the
// source register decides between a bypass select and a hazard.
module hazard_src_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int IDX_W = 5,
    parameter int RF_W  = 1,
    parameter int SEL_W = 2
) (
    input  logic             src_en,
    input  logic [RF_W-1:0]  src_rf,
    input  logic [IDX_W-1:0] src_idx,
    input  sb_entry_t        q [DEPTH],
    output logic             hazard,
    output logic [SEL_W-1:0] fwd_sel
);

    logic src_live;

    // GPR r0 never carries a dependency; FPR f0 is an ordinary register.
    assign src_live = src_en & ~((src_rf == RF_W'(RF_GPR)) & (src_idx == '0));

    // Walk oldest to youngest so the youngest match overrides everything behind it.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = SEL_W'(FWD_REGFILE);
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_live && q[k-1].valid &&
                q[k-1].rf == SB_RF_MAX'(src_rf) &&
                q[k-1].idx == SB_IDX_MAX'(src_idx)) begin
                if (k >= int'(q[k-1].lat)) begin
                    hazard  = 1'b0;
                    fwd_sel = SEL_W'(k);
                end else begin
                    hazard  = 1'b1;
                    fwd_sel = SEL_W'(FWD_REGFILE);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift queue of in-flight register writes,
// per-source bypass selection, decode stall generation and a stall counter.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 5,
    parameter int NUM_RF = 2,
    parameter int RF_W   = 1,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [RF_W-1:0]  issue_rf,
    input  logic [IDX_W-1:0] issue_dst,
    input  logic [SEL_W-1:0] issue_lat,
    input  logic             flush,
    input  logic             src_a_en,
    input  logic [RF_W-1:0]  src_a_rf,
    input  logic [IDX_W-1:0] src_a_idx,
    input  logic             src_b_en,
    input  logic [RF_W-1:0]  src_b_rf,
    input  logic [IDX_W-1:0] src_b_idx,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [31:0]      stall_count
);

    if (NUM_RF > (1 << RF_W) || (1 << SEL_W) < DEPTH + 1 || DEPTH < 2 || DEPTH > 8) begin : g_bad_cfg
        $error("hazard_scoreboard: inconsistent parameters");
    end

    logic             vld_p [DEPTH];
    logic [RF_W-1:0]  rf_p  [DEPTH];
    logic [IDX_W-1:0] idx_p [DEPTH];
    logic [SEL_W-1:0] lat_p [DEPTH];
    sb_entry_t        q     [DEPTH];

    logic             hazard_a;
    logic             hazard_b;
    logic             insert;
    logic [SEL_W-1:0] lat_in;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            q[k]       = '0;
            q[k].valid = vld_p[k];
            q[k].rf    = SB_RF_MAX'(rf_p[k]);
            q[k].idx   = SB_IDX_MAX'(idx_p[k]);
            q[k].lat   = SB_LAT_MAX'(lat_p[k]);
        end
    end

    hazard_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RF_W(RF_W), .SEL_W(SEL_W)) u_match_a (
        .src_en  (src_a_en),
        .src_rf  (src_a_rf),
        .src_idx (src_a_idx),
        .q       (q),
        .hazard  (hazard_a),
        .fwd_sel (fwd_a_sel)
    );

    hazard_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RF_W(RF_W), .SEL_W(SEL_W)) u_match_b (
        .src_en  (src_b_en),
        .src_rf  (src_b_rf),
        .src_idx (src_b_idx),
        .q       (q),
        .hazard  (hazard_b),
        .fwd_sel (fwd_b_sel)
    );

    // A squashed decode slot can neither stall nor enter the queue.
    assign stall  = issue_valid & ~flush & (hazard_a | hazard_b);
    assign insert = issue_valid & issue_we & ~stall & ~flush;
    assign lat_in = (issue_lat == '0) ? SEL_W'(FWD_EX) : issue_lat;

    // Stage boundary: decode -> EX, then one entry per post-decode stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= insert;
            for (int k = 1; k < DEPTH; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        rf_p[0]  <= issue_rf;
        idx_p[0] <= issue_dst;
        lat_p[0] <= lat_in;
        for (int k = 1; k < DEPTH; k++) begin
            rf_p[k]  <= rf_p[k-1];
            idx_p[k] <= idx_p[k-1];
            lat_p[k] <= lat_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand sequences for reset
// and counter saturation, then random traffic against a producer-list model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset, issue_valid, issue_we, flush, src_a_en, src_b_en;
    logic [0:0]  issue_rf, src_a_rf, src_b_rf;
    logic [4:0]  issue_dst, src_a_idx, src_b_idx;
    logic [1:0]  issue_lat, fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rf(issue_rf), .issue_dst(issue_dst), .issue_lat(issue_lat), .flush(flush),
        .src_a_en(src_a_en), .src_a_rf(src_a_rf), .src_a_idx(src_a_idx),
        .src_b_en(src_b_en), .src_b_rf(src_b_rf), .src_b_idx(src_b_idx),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
    );

    typedef struct {
        bit rst; bit iv; bit we; int rf; int dst; int lat; bit fl;
        bit ae; int arf; int aidx; bit be; int brf; int bidx;
        bit e_stall; int e_fa; int e_fb;
    } vec_t;

    // Model: list of in-flight producers, each tagged with the stage it occupies.
    typedef struct { int rf; int idx; int lat; int stage; } prod_t;
    prod_t mq[$];
    longint unsigned mcnt = 0;

    function automatic vec_t mk(bit rst, bit iv, bit we, int rf, int dst, int lat, bit fl,
                                bit ae, int arf, int aidx, bit be, int brf, int bidx,
                                bit es, int fa, int fb);
        vec_t v;
        v.rst = rst; v.iv = iv; v.we = we; v.rf = rf; v.dst = dst; v.lat = lat; v.fl = fl;
        v.ae = ae; v.arf = arf; v.aidx = aidx; v.be = be; v.brf = brf; v.bidx = bidx;
        v.e_stall = es; v.e_fa = fa; v.e_fb = fb;
        return v;
    endfunction

    function automatic vec_t rst_row();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_src(input bit en, input int rf, input int idx, output bit haz, output int sel);
        int best, blat;
        best = DEPTH + 1; blat = 0; haz = 0; sel = 0;
        if (en && !(rf == 0 && idx == 0)) begin
            foreach (mq[i])
                if (mq[i].rf == rf && mq[i].idx == idx && mq[i].stage < best) begin
                    best = mq[i].stage;
                    blat = (mq[i].lat == 0) ? 1 : mq[i].lat;
                end
        end
        if (best <= DEPTH) begin
            if (best >= blat) sel = best;
            else haz = 1;
        end
    endtask

    task automatic model_update(input vec_t v, input bit st);
        prod_t nq[$];
        if (v.rst) begin
            mq.delete();
            mcnt = 0;
            return;
        end
        if (st && mcnt < 64'hFFFF_FFFF) mcnt++;
        foreach (mq[i])
            if (mq[i].stage < DEPTH) nq.push_back('{mq[i].rf, mq[i].idx, mq[i].lat, mq[i].stage + 1});
        if (v.iv && v.we && !st && !v.fl) nq.push_back('{v.rf, v.dst, v.lat, 1});
        mq = nq;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; issue_valid = v.iv; issue_we = v.we; issue_rf = 1'(v.rf);
        issue_dst = 5'(v.dst); issue_lat = 2'(v.lat); flush = v.fl;
        src_a_en = v.ae; src_a_rf = 1'(v.arf); src_a_idx = 5'(v.aidx);
        src_b_en = v.be; src_b_rf = 1'(v.brf); src_b_idx = 5'(v.bidx);
    endtask

    // use_tbl: expectations from the vector; otherwise from the model.
    task automatic step(input vec_t v, input bit use_tbl, input bit cnt_chk, input string nm);
        bit ha, hb, ms, es;
        int ma, mb, ea, eb;
        apply(v);
        #1;
        model_src(v.ae, v.arf, v.aidx, ha, ma);
        model_src(v.be, v.brf, v.bidx, hb, mb);
        ms = v.iv && !v.fl && (ha || hb);
        es = use_tbl ? v.e_stall : ms;
        ea = use_tbl ? v.e_fa : ma;
        eb = use_tbl ? v.e_fb : mb;
        chk({nm, ".stall"}, stall, es);
        if (!es) begin
            chk({nm, ".fwd_a"}, fwd_a_sel, ea);
            chk({nm, ".fwd_b"}, fwd_b_sel, eb);
        end
        if (cnt_chk) chk({nm, ".count"}, stall_count, mcnt);
        model_update(v, ms);
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        apply(rst_row());
        @(negedge clk);

        // rst iv we rf dst lat fl | ae arf aidx | be brf bidx | stall fa fb
        tbl.push_back(rst_row());
        tbl.push_back(mk(0,1,1,0,3,1,0, 0,0,0, 0,0,0, 0,0,0));   // ADD r3
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,3, 0,0,0, 0,1,0));   // read r3 -> EX bypass
        tbl.push_back(rst_row());
        tbl.push_back(mk(0,1,1,0,5,2,0, 0,0,0, 0,0,0, 0,0,0));   // LW r5
        tbl.push_back(mk(0,1,0,0,0,1,0, 0,0,0, 1,0,5, 1,0,0));   // load-use stall
        tbl.push_back(mk(0,1,0,0,0,1,0, 0,0,0, 1,0,5, 0,0,2));   // MEM bypass
        tbl.push_back(rst_row());
        tbl.push_back(mk(0,1,1,0,0,1,0, 0,0,0, 0,0,0, 0,0,0));   // ADD r0
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,0, 0,0,0, 0,0,0));   // read r0 -> regfile
        tbl.push_back(mk(0,1,1,1,0,1,0, 0,0,0, 0,0,0, 0,0,0));   // FPR f0 writer
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,1,0, 0,0,0, 0,1,0));   // read f0 -> EX
        tbl.push_back(rst_row());
        tbl.push_back(mk(0,1,1,0,7,1,0, 0,0,0, 0,0,0, 0,0,0));   // ADD r7
        tbl.push_back(mk(0,1,1,0,7,2,0, 0,0,0, 0,0,0, 0,0,0));   // LW r7
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,7, 0,0,0, 1,0,0));   // youngest not ready
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,7, 0,0,0, 0,2,0));   // youngest now at MEM
        tbl.push_back(rst_row());
        tbl.push_back(mk(0,1,1,0,4,2,0, 0,0,0, 0,0,0, 0,0,0));   // LW r4
        tbl.push_back(mk(0,1,1,0,4,2,1, 1,0,4, 0,0,0, 0,0,0));   // flushed consumer
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0));   // idle
        tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,4, 0,0,0, 0,3,0));   // WB bypass, no flushed entry
        foreach (tbl[i]) step(tbl[i], 1, 1, $sformatf("vec%0d", i));

        // Reset drops three in-flight writers of r9.
        step(rst_row(), 1, 1, "r9.rst0");
        for (int i = 0; i < 3; i++) step(mk(0,1,1,0,9,3,0, 0,0,0, 0,0,0, 0,0,0), 1, 1, "r9.wr");
        step(mk(0,1,0,0,0,1,0, 1,0,9, 0,0,0, 1,0,0), 1, 1, "r9.pre");
        step(rst_row(), 1, 1, "r9.rst");
        step(mk(0,1,0,0,0,1,0, 1,0,9, 0,0,0, 0,0,0), 1, 1, "r9.post");
        chk("r9.count", stall_count, 0);

        // Counter saturation from just below the ceiling.
        step(mk(0,1,1,0,5,3,0, 0,0,0, 0,0,0, 0,0,0), 1, 1, "sat.lw");
        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        step(mk(0,1,1,0,6,3,0, 1,0,5, 0,0,0, 1,0,0), 1, 0, "sat.s1");
        chk("sat.first", stall_count, 32'hFFFF_FFFF);
        step(mk(0,1,1,0,6,3,0, 1,0,5, 0,0,0, 1,0,0), 1, 0, "sat.s2");
        chk("sat.second", stall_count, 32'hFFFF_FFFF);
        step(mk(0,1,1,0,6,3,0, 1,0,5, 0,0,0, 0,3,0), 1, 0, "sat.go");
        step(mk(0,1,0,0,0,1,0, 1,0,6, 0,0,0, 1,0,0), 1, 0, "sat.s3");
        chk("sat.hold", stall_count, 32'hFFFF_FFFF);

        // Random traffic on a small register set so dependencies are frequent.
        step(rst_row(), 1, 0, "rand.rst");
        for (int i = 0; i < 600; i++) begin
            v = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   0, 0, 0);
            step(v, 0, 1, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
